// File: rtl/aes_pkg.sv
// Shared AES-128 types and byte/column helpers for the iterative cipher controller.
// The S-box is computed as GF(2^8) inversion followed by the affine map rather than stored as a table.
package aes_pkg;

    typedef logic [127:0] aes_state_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROUND,
        ST_DONE
    } ctrl_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse (and maps 0 to 0): product of a^2 .. a^128.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = a;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        logic [7:0] r;
        case (rnd)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic aes_state_t sub_bytes(input aes_state_t s);
        aes_state_t o;
        for (int n = 0; n < 16; n++) begin
            o[127-8*n -: 8] = sbox(s[127-8*n -: 8]);
        end
        return o;
    endfunction

    // Byte n sits at row n%4, column n/4; row r rotates left by r columns.
    function automatic aes_state_t shift_rows(input aes_state_t s);
        aes_state_t o;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic aes_state_t mix_columns(input aes_state_t s);
        aes_state_t o;
        for (int c = 0; c < 4; c++) begin
            o[127-32*c -: 32] = mix_column(s[127-32*c -: 32]);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-expansion step: derives the next round key from the previous one and an rcon byte.
module aes_key_step
    import aes_pkg::*;
(
    input  logic [127:0] prev_key,
    input  logic [7:0]   rcon_byte,
    output logic [127:0] next_key
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] t;
    logic [31:0] n0, n1, n2, n3;

    assign w0 = prev_key[127:96];
    assign w1 = prev_key[95:64];
    assign w2 = prev_key[63:32];
    assign w3 = prev_key[31:0];

    // RotWord then SubWord on the last word, folded with the round constant.
    assign t  = sub_word({w3[23:0], w3[31:24]}) ^ {rcon_byte, 24'h000000};
    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_iter_ctrl.sv
// Iterative AES-128 encryptor: one round per clock, valid/ready handshakes on both sides.
// Define AES_ITER_CTRL_ABORT_EN to add an 'abort' input that drops the job in progress.
module aes_iter_ctrl
    import aes_pkg::*;
#(
    parameter int NR = 10
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
`ifdef AES_ITER_CTRL_ABORT_EN
    ,
    input  logic         abort
`endif
);

    localparam logic [3:0] NR_L = 4'(NR);

    ctrl_state_e fsm_q, fsm_d;
    aes_state_t  data_q, data_d;
    logic [127:0] rkey_q, rkey_d;
    logic [3:0]  rnd_q, rnd_d;

    logic       abort_req;
    logic       last_round;
    logic [127:0] round_key;
    aes_state_t shifted;
    aes_state_t mixed;
    aes_state_t round_out;

`ifdef AES_ITER_CTRL_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    aes_key_step u_key_step (
        .prev_key  (rkey_q),
        .rcon_byte (rcon(rnd_q)),
        .next_key  (round_key)
    );

    // The final round bypasses MixColumns.
    assign last_round = (rnd_q == NR_L);
    assign shifted    = shift_rows(sub_bytes(data_q));
    assign mixed      = mix_columns(shifted);
    assign round_out  = (last_round ? shifted : mixed) ^ round_key;

    always_comb begin
        fsm_d  = fsm_q;
        data_d = data_q;
        rkey_d = rkey_q;
        rnd_d  = rnd_q;
        case (fsm_q)
            ST_IDLE: begin
                if (in_valid && !abort_req) begin
                    data_d = in_data ^ in_key;
                    rkey_d = in_key;
                    rnd_d  = 4'd1;
                    fsm_d  = ST_ROUND;
                end
            end
            ST_ROUND: begin
                data_d = round_out;
                rkey_d = round_key;
                if (last_round) begin
                    fsm_d = ST_DONE;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    fsm_d = ST_IDLE;
                    rnd_d = 4'd0;
                end
            end
            default: fsm_d = ST_IDLE;
        endcase
        if (abort_req && fsm_q != ST_IDLE) begin
            fsm_d  = ST_IDLE;
            data_d = '0;
            rkey_d = '0;
            rnd_d  = 4'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q  <= ST_IDLE;
            data_q <= '0;
            rkey_q <= '0;
            rnd_q  <= 4'd0;
        end else begin
            fsm_q  <= fsm_d;
            data_q <= data_d;
            rkey_q <= rkey_d;
            rnd_q  <= rnd_d;
        end
    end

    assign in_ready  = (fsm_q == ST_IDLE);
    assign out_valid = (fsm_q == ST_DONE);
    assign busy      = (fsm_q != ST_IDLE);
    assign out_data  = out_valid ? data_q : '0;

endmodule

// File: tb/tb_aes_iter_ctrl.sv
// Directed bench for aes_iter_ctrl using FIPS-197 and all-zero AES-128 vectors.
// Abort scenarios are exercised when AES_ITER_CTRL_ABORT_EN is defined.
module tb_aes_iter_ctrl;

    localparam int NR      = 10;
    localparam int LATENCY = NR + 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = '0;
    logic [127:0] in_key = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_data;
    logic         busy;
`ifdef AES_ITER_CTRL_ABORT_EN
    logic         abort = 1'b0;
`endif

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
    } vec_t;

    vec_t vecs [3];

    aes_iter_ctrl #(.NR(NR)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
`ifdef AES_ITER_CTRL_ABORT_EN
        ,
        .abort     (abort)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Offers a job at a negedge while IDLE; returns at the negedge right after the accept edge.
    task automatic applyStimulus(input logic [127:0] key, input logic [127:0] pt);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("in_ready before offer", 128'(in_ready), 128'(1));
        in_key   = key;
        in_data  = pt;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_key   = ~key;
        in_data  = ~pt;
    endtask

    // Counts edges from the accept edge (inclusive) until out_valid is seen.
    task automatic waitResult(output int lat);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic runJob(input string name, input vec_t v);
        int lat;
        applyStimulus(v.key, v.pt);
        waitResult(lat);
        checkOutput({name, " latency"}, 128'(lat), 128'(LATENCY));
        checkOutput({name, " data"}, out_data, v.ct);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput({name, " idle after handshake"}, 128'(in_ready), 128'(1));
        checkOutput({name, " out_data zero when idle"}, out_data, '0);
    endtask

    initial begin
        int lat;
        int acc;
        int out_idx;
        int acc_cycle [3];
        logic seen_valid;

        vecs[0] = '{key: 128'h000102030405060708090a0b0c0d0e0f,
                    pt:  128'h00112233445566778899aabbccddeeff,
                    ct:  128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vecs[1] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    pt:  128'h3243f6a8885a308d313198a2e0370734,
                    ct:  128'h3925841d02dc09fbdc118597196a0b32};
        vecs[2] = '{key: 128'h0,
                    pt:  128'h0,
                    ct:  128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

        // Reset values while rst is held, with a job offered that must be ignored
        in_valid = 1'b1;
        in_key   = vecs[0].key;
        in_data  = vecs[0].pt;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset in_ready", 128'(in_ready), 128'(1));
        checkOutput("reset out_valid", 128'(out_valid), 128'(0));
        checkOutput("reset busy", 128'(busy), 128'(0));
        checkOutput("reset out_data", out_data, '0);
        in_valid = 1'b0;
        rst = 1'b0;

        // Table-driven known-answer jobs
        for (int i = 0; i < 3; i++) begin
            runJob($sformatf("vec%0d", i), vecs[i]);
        end

        // Consumer stall: output held, new offer ignored, accepted only after IDLE
        applyStimulus(vecs[0].key, vecs[0].pt);
        waitResult(lat);
        checkOutput("stall latency", 128'(lat), 128'(LATENCY));
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_key   = vecs[1].key;
            in_data  = vecs[1].pt;
            checkOutput($sformatf("stall data c%0d", i), out_data, vecs[0].ct);
            checkOutput($sformatf("stall in_ready c%0d", i), 128'(in_ready), 128'(0));
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("release in_ready", 128'(in_ready), 128'(1));
        checkOutput("release out_valid", 128'(out_valid), 128'(0));
        checkOutput("release out_data", out_data, '0);
        checkOutput("release busy", 128'(busy), 128'(0));
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("second job accepted", 128'(busy), 128'(1));
        waitResult(lat);
        checkOutput("second job latency", 128'(lat), 128'(LATENCY));
        checkOutput("second job data", out_data, vecs[1].ct);
        out_ready = 1'b1;
        @(negedge clk);

        // Back-to-back with in_valid and out_ready tied high
        acc = 0;
        out_idx = 0;
        for (int i = 0; i < 50; i++) begin
            if (out_valid) begin
                if (out_idx < 3) begin
                    checkOutput($sformatf("b2b data job%0d", out_idx), out_data, vecs[out_idx].ct);
                end
                out_idx++;
            end
            if (in_ready && acc < 3) begin
                in_key       = vecs[acc].key;
                in_data      = vecs[acc].pt;
                in_valid     = 1'b1;
                acc_cycle[acc] = i;
                acc++;
            end else if (acc >= 3) begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
        checkOutput("b2b result count", 128'(out_idx), 128'(3));
        checkOutput("b2b accept count", 128'(acc), 128'(3));
        checkOutput("b2b spacing 0-1", 128'(acc_cycle[1] - acc_cycle[0]), 128'(NR + 2));
        checkOutput("b2b spacing 1-2", 128'(acc_cycle[2] - acc_cycle[1]), 128'(NR + 2));

        // Asynchronous reset in the middle of round 5
        applyStimulus(vecs[1].key, vecs[1].pt);
        for (int i = 0; i < 4; i++) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("async rst in_ready", 128'(in_ready), 128'(1));
        checkOutput("async rst out_valid", 128'(out_valid), 128'(0));
        checkOutput("async rst busy", 128'(busy), 128'(0));
        checkOutput("async rst out_data", out_data, '0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen_valid = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid) seen_valid = 1'b1;
            @(negedge clk);
        end
        checkOutput("no output after reset discard", 128'(seen_valid), 128'(0));
        runJob("post-reset vec0", vecs[0]);

`ifdef AES_ITER_CTRL_ABORT_EN
        // Abort at round 3
        applyStimulus(vecs[0].key, vecs[0].pt);
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort round in_ready", 128'(in_ready), 128'(1));
        checkOutput("abort round busy", 128'(busy), 128'(0));
        seen_valid = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid) seen_valid = 1'b1;
            @(negedge clk);
        end
        checkOutput("abort round no output", 128'(seen_valid), 128'(0));

        // Abort while the result waits in DONE
        applyStimulus(vecs[1].key, vecs[1].pt);
        waitResult(lat);
        checkOutput("abort done latency", 128'(lat), 128'(LATENCY));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort done out_valid", 128'(out_valid), 128'(0));
        checkOutput("abort done out_data", out_data, '0);

        // Abort in IDLE blocks a simultaneous offer
        abort    = 1'b1;
        in_valid = 1'b1;
        in_key   = vecs[2].key;
        in_data  = vecs[2].pt;
        @(negedge clk);
        abort    = 1'b0;
        in_valid = 1'b0;
        checkOutput("abort idle offer ignored", 128'(busy), 128'(0));
        runJob("post-abort vec2", vecs[2]);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
